// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the 64 x 8 single-clock byte FIFO.
// The occupancy counter is one bit wider than the pointers so that it can hold the value DEPTH.
package sync_fifo_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage array: DEPTH x DATA_W registers.
// Writes are synchronous. Reads are combinational, so the top level registers the read data.
module sync_fifo_mem
  import sync_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  data_t             wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output data_t             rd_data
);

  // Storage is not reset; reset only clears the pointers and the counter.
  data_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data and occupancy reporting.
// Optional registered overflow/underflow pulses are enabled with SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo
  import sync_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [DATA_W-1:0] buf_in,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [CNT_W-1:0]  fifo_counter
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  data_t             buf_out_q, buf_out_d;
  data_t             mem_rd_data;
  logic              wr_acc, rd_acc;

  assign buf_empty    = (cnt_q == '0);
  assign buf_full     = (cnt_q == CNT_W'(DEPTH));
  assign fifo_counter = cnt_q;
  assign buf_out      = buf_out_q;

  // The full and empty checks decide the simultaneous cases: at full only the read is accepted,
  // and at empty only the write is accepted, so no data bypasses the memory.
  assign wr_acc = wr_en & ~buf_full;
  assign rd_acc = rd_en & ~buf_empty;

  sync_fifo_mem u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (buf_in),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    buf_out_d = buf_out_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      buf_out_d = mem_rd_data;
    end
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      buf_out_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      buf_out_q <= buf_out_d;
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = wr_en & buf_full;
    underflow_d = rd_en & buf_empty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed testbench for sync_fifo: reset, ordering, full/empty boundaries, pointer wrap,
// simultaneous read/write and asynchronous reset in the middle of traffic.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] buf_in;
  logic [DATA_W-1:0] buf_out;
  logic              buf_empty;
  logic              buf_full;
  logic [CNT_W-1:0]  fifo_counter;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  sync_fifo dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .buf_in       (buf_in),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .fifo_counter (fifo_counter)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow     (overflow),
    .underflow    (underflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests; outputs are stable 1 time unit after the edge.
  task automatic cyc(input logic w, input logic r, input logic [DATA_W-1:0] d);
    wr_en  = w;
    rd_en  = r;
    buf_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] exp_b;
    rst    = 1'b0;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    buf_in = '0;
    #3;
    chk("rst_empty", 32'(buf_empty), 32'd1);
    chk("rst_full", 32'(buf_full), 32'd0);
    chk("rst_cnt", 32'(fifo_counter), 32'd0);
    chk("rst_bufout", 32'(buf_out), 32'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;

    cyc(1'b1, 1'b0, 8'h32);
    cyc(1'b1, 1'b0, 8'h1D);
    cyc(1'b1, 1'b0, 8'h3D);
    chk("wr3_cnt", 32'(fifo_counter), 32'd3);
    chk("wr3_empty", 32'(buf_empty), 32'd0);

    cyc(1'b0, 1'b1, 8'h00);
    chk("rd1_data", 32'(buf_out), 32'h32);
    cyc(1'b0, 1'b1, 8'h00);
    chk("rd2_data", 32'(buf_out), 32'h1D);
    chk("rd2_cnt", 32'(fifo_counter), 32'd1);

    for (int i = 0; i < 63; i++) begin
      cyc(1'b1, 1'b0, 8'(i));
    end
    chk("fill_cnt", 32'(fifo_counter), 32'd64);
    chk("fill_full", 32'(buf_full), 32'd1);
    cyc(1'b1, 1'b0, 8'hAA);
    chk("ovf_cnt", 32'(fifo_counter), 32'd64);
    chk("ovf_full", 32'(buf_full), 32'd1);
    chk("ovf_bufout", 32'(buf_out), 32'h1D);

    for (int i = 0; i < 64; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      exp_b = (i == 0) ? 8'h3D : 8'(i - 1);
      chk("drain_data", 32'(buf_out), 32'(exp_b));
    end
    chk("drain_empty", 32'(buf_empty), 32'd1);
    chk("drain_cnt", 32'(fifo_counter), 32'd0);
    chk("drain_last", 32'(buf_out), 32'h3E);
    cyc(1'b0, 1'b1, 8'h00);
    chk("udf_hold", 32'(buf_out), 32'h3E);
    chk("udf_cnt", 32'(fifo_counter), 32'd0);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'(8'h10 + i));
    end
    cyc(1'b1, 1'b1, 8'h15);
    chk("rw5_cnt", 32'(fifo_counter), 32'd5);
    chk("rw5_data", 32'(buf_out), 32'h10);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      chk("rw5_order", 32'(buf_out), 32'(8'h11 + i));
    end
    chk("rw5_empty", 32'(buf_empty), 32'd1);

    cyc(1'b1, 1'b1, 8'h77);
    chk("rwe_cnt", 32'(fifo_counter), 32'd1);
    chk("rwe_hold", 32'(buf_out), 32'h15);
    chk("rwe_empty", 32'(buf_empty), 32'd0);
    cyc(1'b0, 1'b1, 8'h00);
    chk("rwe_data", 32'(buf_out), 32'h77);

    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    wr_en  = 1'b1;
    buf_in = 8'h03;
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(fifo_counter), 32'd0);
    chk("mid_rst_empty", 32'(buf_empty), 32'd1);
    chk("mid_rst_full", 32'(buf_full), 32'd0);
    chk("mid_rst_bufout", 32'(buf_out), 32'h00);
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);
    chk("post_rst_data", 32'(buf_out), 32'h5A);
    chk("post_rst_cnt", 32'(fifo_counter), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
